pattern_match_sched: RTL and testbench

//   Round-robin scheduler that shares one programmable serial pattern matcher

---
 rtl/pms_pkg.sv | 11 +
 rtl/pms_match_core.sv | 37 +++
 rtl/pattern_match_sched.sv | 78 +++++++
 tb/tb_pattern_match_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pms_pkg.sv
// pms_pkg: shared state codes, reset defaults and round-robin search for pattern_match_sched.
package pms_pkg;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, REPORT = 2'd2;
  localparam logic [31:0] PAT_RST = 32'b101;
  localparam logic [31:0] MASK_RST = '1;
  // Descending scan so the smallest wrap-around offset from last is the one kept.
  function automatic int rr_next(input logic [31:0] req, input int n, input int last);
    rr_next = last;
    for (int i = n; i >= 1; i--) if (req[(last + i) % n]) rr_next = (last + i) % n;
  endfunction
endpackage

// File: rtl/pms_match_core.sv
// pms_match_core: serial masked pattern matcher; PMS_OVERLAP_EN keeps history after a match.
module pms_match_core #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             serial_bit,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] mask,
  output logic [CNT_W-1:0] count
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist, hist_nx;
  logic [FILL_W-1:0] fill, fill_nx;
  logic match;
  assign hist_nx = PAT_W'({hist, serial_bit});
  assign fill_nx = fill == FILL_W'(PAT_W) ? fill : fill + 1'b1;
  assign match = bit_en && fill_nx == FILL_W'(PAT_W) && ((hist_nx ^ pattern) & mask) == '0;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
    end else if (bit_en) begin
      hist  <= hist_nx;
`ifdef PMS_OVERLAP_EN
      fill  <= fill_nx;
`else
      fill  <= match ? '0 : fill_nx;
`endif
      count <= count + CNT_W'(match);
    end
  end
endmodule

// File: rtl/pattern_match_sched.sv
// pattern_match_sched: round-robin arbiter sharing one serial pattern matcher among NUM_CH requesters.
// Optional PMS_OVERLAP_EN counts overlapping matches.
module pattern_match_sched
  import pms_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 16,
  parameter int PAT_W   = 3,
  parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [PAT_W-1:0]            cfg_pattern,
  input  logic [PAT_W-1:0]            cfg_mask,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*FRAME_W-1:0]   req_data,
  output logic [NUM_CH-1:0]           req_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(NUM_CH)-1:0]   res_ch,
  output logic [CNT_W-1:0]            res_count,
  output logic                        busy
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int BC_W = $clog2(FRAME_W + 1);
  logic [1:0] state;
  logic [PAT_W-1:0] pattern, mask;
  logic [CH_W-1:0] last_grant, winner;
  logic [FRAME_W-1:0] frame;
  logic [BC_W-1:0] bit_cnt;
  logic grant;
  assign winner = CH_W'(rr_next(32'(req_valid), NUM_CH, int'(last_grant)));
  // A config write in IDLE takes the cycle, so no grant alongside it.
  assign grant = !reset && state == IDLE && !cfg_we && |req_valid;
  assign req_ready = grant ? {{(NUM_CH-1){1'b0}}, 1'b1} << winner : '0;
  assign res_valid = state == REPORT;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pattern    <= PAT_W'(PAT_RST);
      mask       <= PAT_W'(MASK_RST);
      last_grant <= CH_W'(NUM_CH - 1);
      res_ch     <= '0;
      frame      <= '0;
      bit_cnt    <= '0;
    end else begin
      if (state == IDLE && cfg_we) begin
        pattern <= cfg_pattern;
        mask    <= cfg_mask;
      end
      if (grant) begin
        frame      <= req_data[winner*FRAME_W +: FRAME_W];
        last_grant <= winner;
        res_ch     <= winner;
        bit_cnt    <= '0;
        state      <= RUN;
      end
      if (state == RUN) begin
        frame   <= frame << 1;
        bit_cnt <= bit_cnt + 1'b1;
        state   <= bit_cnt == BC_W'(FRAME_W - 1) ? REPORT : RUN;
      end
      if (state == REPORT && res_ready) state <= IDLE;
    end
  end
  pms_match_core #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_core (
    .clk(clk),
    .reset(reset),
    .clear(grant),
    .bit_en(state == RUN),
    .serial_bit(frame[FRAME_W-1]),
    .pattern(pattern),
    .mask(mask),
    .count(res_count)
  );
endmodule

// File: tb/tb_pattern_match_sched.sv
// tb_pattern_match_sched: directed scoreboard bench for pattern_match_sched (NUM_CH=4, FRAME_W=16, PAT_W=3).
module tb_pattern_match_sched;
  logic clk = 0, reset = 1, cfg_we = 0, res_ready = 0;
  logic [2:0] cfg_pattern = 3'b101, cfg_mask = 3'b111;
  logic [3:0] req_valid = 0, req_ready;
  logic [63:0] req_data = 0;
  logic res_valid, busy;
  logic [1:0] res_ch;
  logic [4:0] res_count;
  int checks = 0, failures = 0;
  logic [2:0] cur_pat = 3'b101, cur_mask = 3'b111;
  logic [6:0] sb[$];
  logic [6:0] exp_res;

  pattern_match_sched dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(input logic [15:0] f, input logic [2:0] p, input logic [2:0] m);
    logic [2:0] h = 0;
    int fill = 0;
    logic [4:0] c = 0;
    for (int i = 15; i >= 0; i--) begin
      h = {h[1:0], f[i]};
      if (fill < 3) fill++;
      if (fill == 3 && ((h ^ p) & m) == 0) begin
        c++;
`ifndef PMS_OVERLAP_EN
        fill = 0;
`endif
      end
    end
    return c;
  endfunction

  // Called just after a negedge; leaves res_ready high at a negedge in REPORT.
  task automatic serve(input int ch, input int stall, input bit cfg_mid);
    int n = 0, extra = 0;
    #1;
    while (req_ready == 0 && n < 40) begin
      @(negedge clk);
      res_ready = 0;
      #1;
      n++;
    end
    chk($sformatf("grant_ch%0d", ch), req_ready, 32'(1) << ch);
    if (req_ready == 0) return;
    sb.push_back({2'(ch), model(req_data[ch*16 +: 16], cur_pat, cur_mask)});
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (req_ready != 0) extra++;
      if (cfg_mid && n == 3) begin
        cfg_we = 1;
        cfg_pattern = 3'b111;
        cfg_mask = 3'b111;
      end else cfg_we = 0;
    end while (!res_valid && n < 40);
    chk("latency", n, 17);
    chk("no_extra_grant", extra, 0);
    exp_res = sb.pop_front();
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_ch", res_ch, exp_res[6:5]);
      chk("stall_count", res_count, exp_res[4:0]);
      chk("stall_no_grant", req_ready, 0);
    end
    chk("res_ch", res_ch, exp_res[6:5]);
    chk("res_count", res_count, exp_res[4:0]);
    res_ready = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_res_count", res_count, 0);
    // Default 101 pattern and all-ones mask on ch0.
    req_data[15:0] = 16'hA800;
    req_valid = 4'b0001;
    serve(0, 0, 0);
`ifdef PMS_OVERLAP_EN
    chk("a800_count", exp_res[4:0], 2);
`else
    chk("a800_count", exp_res[4:0], 1);
`endif
    req_valid = 4'b0000;
    // Round-robin between ch1 and ch3 with requests held.
    @(negedge clk);
    res_ready = 0;
    req_data[31:16] = 16'hB5AD;
    req_data[63:48] = 16'h5555;
    req_valid = 4'b1010;
    serve(1, 0, 0);
    serve(3, 0, 0);
    serve(1, 0, 0);
    req_valid = 4'b0000;
    // Back-pressure on the result port.
    @(negedge clk);
    res_ready = 0;
    req_data[47:32] = 16'hA5A5;
    req_valid = 4'b0100;
    serve(2, 5, 0);
    req_valid = 4'b0000;
    // Mask=0 config, then a config write during RUN that must be ignored.
    @(negedge clk);
    res_ready = 0;
    cfg_we = 1;
    cfg_pattern = 3'b101;
    cfg_mask = 3'b000;
    @(negedge clk);
    cfg_we = 0;
    #1;
    chk("cfg_cycle_no_grant", req_ready, 0);
    cur_mask = 3'b000;
    req_data[15:0] = 16'h1234;
    req_valid = 4'b0011;
    serve(0, 0, 1);
`ifdef PMS_OVERLAP_EN
    chk("mask0_count", exp_res[4:0], 14);
`else
    chk("mask0_count", exp_res[4:0], 5);
`endif
    serve(1, 0, 0);
    req_valid = 4'b0000;
    // Reset in the middle of RUN drops the frame.
    @(negedge clk);
    res_ready = 0;
    req_data[63:48] = 16'hA800;
    req_valid = 4'b1000;
    #1;
    chk("pre_reset_grant", req_ready, 4'b1000);
    repeat (5) @(negedge clk);
    #1;
    chk("mid_run_busy", busy, 1);
    reset = 1;
    req_valid = 4'b0000;
    @(negedge clk);
    reset = 0;
    #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", res_valid, 0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        #1;
        if (res_valid) seen++;
      end
      chk("no_dropped_result", seen, 0);
    end
    cur_pat = 3'b101;
    cur_mask = 3'b111;
    req_valid = 4'b1000;
    serve(3, 0, 0);
    req_valid = 4'b0000;
    @(negedge clk);
    res_ready = 0;
    #1;
    chk("final_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
